// File: rtl/ps2_key_event_fifo.sv
`default_nettype none
// ============================================================================
// ps2_key_event_fifo : PS/2 receiver on the system clock, F0/E0 folded into
//                      key events, buffered in a show-ahead valid/ready FIFO.
// Revision 1.0
// ============================================================================
module ps2_key_event_fifo #(
  parameter int FILTER_LEN     = 8,
  parameter int TIMEOUT_CYCLES = 200000,
  parameter int FIFO_DEPTH     = 8,
  parameter int CNT_W          = 4
) (
  input  logic             CLK100MHZ,
  input  logic             reset,
  input  logic             PS2_CLK,
  input  logic             PS2_DATA,
  output logic             evt_valid,
  input  logic             evt_ready,
  output logic [7:0]       evt_code,
  output logic             evt_break,
  output logic             evt_ext,
  output logic [CNT_W-1:0] fifo_count,
  output logic [7:0]       last_code,
  output logic             overflow,
  output logic             frame_err
);

  localparam int c_AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int c_FW = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;
  localparam int c_TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [c_FW-1:0]  c_FLT_MAX = c_FW'(FILTER_LEN - 1);
  localparam logic [c_TW-1:0]  c_TMO_MAX = c_TW'(TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] c_FULL    = CNT_W'(FIFO_DEPTH);
  localparam logic [7:0]       c_BRK     = 8'hF0;
  localparam logic [7:0]       c_EXT     = 8'hE0;

  // --------------------------------------------------------------------------
  // Synchronisers and clock glitch filter (lines idle high)
  // --------------------------------------------------------------------------
  logic [1:0]      clk_s_q;
  logic [1:0]      dat_s_q;
  logic            filt_clk_q;
  logic [c_FW-1:0] filt_cnt_q;
  logic            w_fall;
  logic            w_dat;

  always_ff @(posedge CLK100MHZ or posedge reset) begin
    if (reset) begin
      clk_s_q    <= 2'b11;
      dat_s_q    <= 2'b11;
      filt_clk_q <= 1'b1;
      filt_cnt_q <= '0;
    end else begin
      clk_s_q <= {clk_s_q[0], PS2_CLK};
      dat_s_q <= {dat_s_q[0], PS2_DATA};
      if (clk_s_q[1] == filt_clk_q) begin
        filt_cnt_q <= '0;
      end else if (filt_cnt_q == c_FLT_MAX) begin
        filt_clk_q <= clk_s_q[1];
        filt_cnt_q <= '0;
      end else begin
        filt_cnt_q <= filt_cnt_q + c_FW'(1);
      end
    end
  end

  // One-cycle strobe in the cycle the filtered clock is about to drop
  assign w_fall = filt_clk_q & ~clk_s_q[1] & (filt_cnt_q == c_FLT_MAX);
  assign w_dat  = dat_s_q[1];

  // --------------------------------------------------------------------------
  // Frame FSM
  // --------------------------------------------------------------------------
  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_DATA   = 2'd1,
    S_PARITY = 2'd2,
    S_STOP   = 2'd3
  } state_t;

  state_t          state_q;
  logic [2:0]      bit_cnt_q;
  logic [7:0]      shift_q;
  logic            par_q;
  logic [c_TW-1:0] tmo_q;
  logic            byte_ok_q;
  logic            byte_bad_q;
  logic            frame_err_q;

  always_ff @(posedge CLK100MHZ or posedge reset) begin
    if (reset) begin
      state_q     <= S_IDLE;
      bit_cnt_q   <= '0;
      shift_q     <= '0;
      par_q       <= 1'b0;
      tmo_q       <= '0;
      byte_ok_q   <= 1'b0;
      byte_bad_q  <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      byte_ok_q  <= 1'b0;
      byte_bad_q <= 1'b0;
      if (w_fall) begin
        tmo_q <= '0;
        case (state_q)
          S_IDLE: begin
            if (!w_dat) begin
              state_q   <= S_DATA;
              bit_cnt_q <= '0;
            end
          end
          S_DATA: begin
            shift_q   <= {w_dat, shift_q[7:1]};
            bit_cnt_q <= bit_cnt_q + 3'd1;
            if (bit_cnt_q == 3'd7) state_q <= S_PARITY;
          end
          S_PARITY: begin
            par_q   <= w_dat;
            state_q <= S_STOP;
          end
          default: begin
            if (w_dat && (^{shift_q, par_q})) begin
              byte_ok_q <= 1'b1;
            end else begin
              byte_bad_q  <= 1'b1;
              frame_err_q <= 1'b1;
            end
            state_q <= S_IDLE;
          end
        endcase
      end else if (state_q != S_IDLE) begin
        if (tmo_q == c_TMO_MAX) begin
          state_q     <= S_IDLE;
          frame_err_q <= 1'b1;
          tmo_q       <= '0;
        end else begin
          tmo_q <= tmo_q + c_TW'(1);
        end
      end else begin
        tmo_q <= '0;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Prefix decode
  // --------------------------------------------------------------------------
  logic [7:0] last_code_q;
  logic       brk_q;
  logic       ext_q;
  logic       push_q;
  logic [9:0] push_data_q;

  always_ff @(posedge CLK100MHZ or posedge reset) begin
    if (reset) begin
      last_code_q <= '0;
      brk_q       <= 1'b0;
      ext_q       <= 1'b0;
      push_q      <= 1'b0;
      push_data_q <= '0;
    end else begin
      push_q <= 1'b0;
      if (byte_ok_q) begin
        last_code_q <= shift_q;
        if (shift_q == c_BRK) begin
          brk_q <= 1'b1;
        end else if (shift_q == c_EXT) begin
          ext_q <= 1'b1;
        end else begin
          push_q      <= 1'b1;
          push_data_q <= {ext_q, brk_q, shift_q};
          brk_q       <= 1'b0;
          ext_q       <= 1'b0;
        end
      end else if (byte_bad_q) begin
        brk_q <= 1'b0;
        ext_q <= 1'b0;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Show-ahead event FIFO
  // --------------------------------------------------------------------------
  logic [9:0]       mem_q [FIFO_DEPTH];
  logic [c_AW-1:0]  wr_ptr_q;
  logic [c_AW-1:0]  rd_ptr_q;
  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;
  logic             valid_q;
  logic             overflow_q;
  logic             w_full;
  logic             w_pop;
  logic             w_push;

  assign w_full = (count_q == c_FULL);
  assign w_pop  = valid_q & evt_ready;
  // When full, a simultaneous pop frees the slot being written
  assign w_push = push_q & (~w_full | w_pop);

  always_comb begin
    count_d = count_q + CNT_W'(w_push) - CNT_W'(w_pop);
  end

  always_ff @(posedge CLK100MHZ or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      valid_q    <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      if (w_push) begin
        mem_q[wr_ptr_q] <= push_data_q;
        wr_ptr_q        <= wr_ptr_q + c_AW'(1);
      end
      if (w_pop) rd_ptr_q <= rd_ptr_q + c_AW'(1);
      if (push_q && w_full && !w_pop) overflow_q <= 1'b1;
      count_q <= count_d;
      valid_q <= (count_d != '0);
    end
  end

  assign evt_valid  = valid_q;
  assign evt_code   = mem_q[rd_ptr_q][7:0];
  assign evt_break  = mem_q[rd_ptr_q][8];
  assign evt_ext    = mem_q[rd_ptr_q][9];
  assign fifo_count = count_q;
  assign last_code  = last_code_q;
  assign overflow   = overflow_q;
  assign frame_err  = frame_err_q;

endmodule
`default_nettype wire

// File: tb/tb_ps2_key_event_fifo.sv
`default_nettype none
// ============================================================================
// tb_ps2_key_event_fifo : PS/2 frames in, key events checked against a
//                         byte-level event model; directed plus random phases.
// Revision 1.0
// ============================================================================
module tb_ps2_key_event_fifo;

  localparam int c_HALF  = 20;
  localparam int c_TMO   = 300;
  localparam int c_DEPTH = 8;
  localparam int c_CW    = 4;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            ps2_clk = 1'b1;
  logic            ps2_dat = 1'b1;
  logic            evt_ready = 1'b0;
  logic            evt_valid;
  logic [7:0]      evt_code;
  logic            evt_break;
  logic            evt_ext;
  logic [c_CW-1:0] fifo_count;
  logic [7:0]      last_code;
  logic            overflow;
  logic            frame_err;

  ps2_key_event_fifo #(
    .FILTER_LEN    (8),
    .TIMEOUT_CYCLES(c_TMO),
    .FIFO_DEPTH    (c_DEPTH),
    .CNT_W         (c_CW)
  ) u_dut (
    .CLK100MHZ (clk),
    .reset     (rst),
    .PS2_CLK   (ps2_clk),
    .PS2_DATA  (ps2_dat),
    .evt_valid (evt_valid),
    .evt_ready (evt_ready),
    .evt_code  (evt_code),
    .evt_break (evt_break),
    .evt_ext   (evt_ext),
    .fifo_count(fifo_count),
    .last_code (last_code),
    .overflow  (overflow),
    .frame_err (frame_err)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Reference model: expected events {ext,brk,code} from the byte stream
  logic [9:0] exp_q[$];
  bit         m_brk, m_ext, m_ovf, m_ferr;
  logic [7:0] m_last;
  int         m_npush;
  int         n_evt;
  int         max_cnt;

  function automatic void model_byte(input logic [7:0] b, input bit good);
    if (!good) begin
      m_brk  = 1'b0;
      m_ext  = 1'b0;
      m_ferr = 1'b1;
      return;
    end
    m_last = b;
    if (b == 8'hF0) m_brk = 1'b1;
    else if (b == 8'hE0) m_ext = 1'b1;
    else begin
      if (exp_q.size() < c_DEPTH) begin
        exp_q.push_back({m_ext, m_brk, b});
        m_npush++;
      end else begin
        m_ovf = 1'b1;
      end
      m_brk = 1'b0;
      m_ext = 1'b0;
    end
  endfunction

  // Consumer: ready is either fixed or randomised per cycle
  bit   rand_ready  = 1'b0;
  logic ready_fixed = 1'b0;

  initial begin
    forever begin
      @(posedge clk);
      #1 evt_ready = rand_ready ? logic'($urandom_range(0, 1)) : ready_fixed;
    end
  end

  initial begin
    logic [9:0] want;
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (int'(fifo_count) > max_cnt) max_cnt = int'(fifo_count);
        if (evt_valid && evt_ready) begin
          n_evt++;
          check("evt_pending", 32'(exp_q.size() != 0), 32'd1);
          if (exp_q.size() != 0) begin
            want = exp_q.pop_front();
            check("evt_head", {22'd0, evt_ext, evt_break, evt_code}, {22'd0, want});
          end
        end
      end
    end
  end

  task automatic ps2_bit(input logic v);
    ps2_dat = v;
    repeat (c_HALF) @(posedge clk);
    ps2_clk = 1'b0;
    repeat (c_HALF) @(posedge clk);
    ps2_clk = 1'b1;
  endtask

  task automatic send_byte(input logic [7:0] b, input bit bad_par);
    logic par;
    par = (~^b) ^ bad_par;
    ps2_bit(1'b0);
    for (int i = 0; i < 8; i++) ps2_bit(b[i]);
    ps2_bit(par);
    ps2_dat = 1'b1;
    repeat (c_HALF) @(posedge clk);
    ps2_clk = 1'b0;
    model_byte(b, !bad_par);
    repeat (c_HALF) @(posedge clk);
    ps2_clk = 1'b1;
    repeat (40) @(posedge clk);
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1 rst = 1'b1;
    exp_q.delete();
    m_brk = 0; m_ext = 0; m_ovf = 0; m_ferr = 0;
    m_last = 8'h00; m_npush = 0; n_evt = 0; max_cnt = 0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic wait_idle(input string tag);
    int  t;
    bit  done;
    done = 1'b0;
    for (t = 0; t < 2000 && !done; t++) begin
      @(negedge clk);
      if (exp_q.size() == 0 && fifo_count == '0 && !evt_valid) done = 1'b1;
    end
    check(tag, 32'(done), 32'd1);
  endtask

  task automatic check_status(input string tag);
    @(negedge clk);
    check({tag, "_last"}, 32'(last_code), 32'(m_last));
    check({tag, "_nevt"}, 32'(n_evt), 32'(m_npush));
    check({tag, "_ferr"}, 32'(frame_err), 32'(m_ferr));
  endtask

  initial begin
    int kind;
    logic [7:0] code;
    bit bad;

    do_reset();
    check("rst_valid", 32'(evt_valid), 0);
    check("rst_count", 32'(fifo_count), 0);
    check("rst_last",  32'(last_code), 0);
    check("rst_ovf",   32'(overflow), 0);
    check("rst_ferr",  32'(frame_err), 0);
    check("rst_head",  {22'd0, evt_ext, evt_break, evt_code}, 0);

    // T1: single make
    ready_fixed = 1'b1;
    send_byte(8'h1C, 0);
    wait_idle("t1_drain");
    check_status("t1");

    // T2: break code folds into one event
    max_cnt = 0;
    send_byte(8'hF0, 0);
    send_byte(8'h1C, 0);
    wait_idle("t2_drain");
    check_status("t2");
    check("t2_maxcnt", 32'(max_cnt), 32'd1);

    // T3: extended release then plain make
    send_byte(8'hE0, 0);
    send_byte(8'hF0, 0);
    send_byte(8'h75, 0);
    send_byte(8'h75, 0);
    wait_idle("t3_drain");
    check_status("t3");

    // T4: overflow with consumer stalled
    ready_fixed = 1'b0;
    check("t4_ovf_pre", 32'(overflow), 0);
    for (int i = 0; i < 10; i++) send_byte(8'(8'h10 + i), 0);
    @(negedge clk);
    check("t4_count", 32'(fifo_count), c_DEPTH);
    check("t4_ovf", 32'(overflow), 32'(m_ovf));
    check("t4_valid", 32'(evt_valid), 1);
    ready_fixed = 1'b1;
    wait_idle("t4_drain");
    check_status("t4");

    // T6: timeout mid-frame keeps prefix flags
    do_reset();
    check("t6_ovf_rst", 32'(overflow), 0);
    send_byte(8'hE0, 0);
    ps2_bit(1'b0);
    for (int i = 0; i < 4; i++) ps2_bit(1'b1);
    ps2_dat = 1'b1;
    repeat (c_TMO + 50) @(posedge clk);
    m_ferr = 1'b1;
    @(negedge clk);
    check("t6_ferr", 32'(frame_err), 1);
    send_byte(8'h75, 0);
    wait_idle("t6_drain");
    check_status("t6");

    // T5: parity error, dropped byte clears prefix, clock glitch
    do_reset();
    check("t5_ferr_rst", 32'(frame_err), 0);
    send_byte(8'h1C, 1);
    send_byte(8'h32, 0);
    wait_idle("t5_drain_a");
    check_status("t5a");
    send_byte(8'hF0, 0);
    send_byte(8'h1C, 1);
    send_byte(8'h32, 0);
    wait_idle("t5_drain_b");
    check_status("t5b");
    ps2_dat = 1'b0;
    @(posedge clk);
    ps2_clk = 1'b0;
    repeat (3) @(posedge clk);
    ps2_clk = 1'b1;
    repeat (50) @(posedge clk);
    ps2_dat = 1'b1;
    repeat (20) @(posedge clk);
    send_byte(8'h1C, 0);
    wait_idle("t5_drain_c");
    check_status("t5c");

    // Random key events with a random-ready consumer
    do_reset();
    rand_ready = 1'b1;
    for (int n = 0; n < 16; n++) begin
      kind = int'($urandom_range(0, 3));
      code = 8'($urandom_range(1, 8'h83));
      bad  = ($urandom_range(0, 7) == 0);
      if (kind[1]) send_byte(8'hE0, 0);
      if (kind[0]) send_byte(8'hF0, 0);
      send_byte(code, bad);
    end
    wait_idle("rnd_drain");
    rand_ready = 1'b0;
    check_status("rnd");
    check("rnd_ovf", 32'(overflow), 32'(m_ovf));

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
